// File: rtl/wb_pkg.sv
// Shared constants for the write-back side of the core.
//   - WD_SEL_*  : write-back data select encodings (anything else selects zero).
//   - F3_*      : load funct3 encodings understood by load_ext.
package wb_pkg;

  localparam logic [2:0] WD_SEL_ALU  = 3'd1;
  localparam logic [2:0] WD_SEL_DMEM = 3'd2;
  localparam logic [2:0] WD_SEL_UEXT = 3'd3;
  localparam logic [2:0] WD_SEL_PC4  = 3'd4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_ext.sv
// Combinational load-data extractor.
// Picks the byte / half / word addressed by the byte offset out of an aligned
// little-endian DMEM word and sign- or zero-extends it to XLEN.
// Ports:
//   funct3 : load type (LB/LH/LW/LBU/LHU; other codes fault)
//   off    : byte offset within the word (address bits [1:0])
//   word   : raw aligned word read from DMEM
//   data   : extracted, extended load data (0 on fault)
//   fault  : misaligned access or unsupported funct3
module load_ext
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data,
  output logic            fault
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte lane k sits at word[8k+7:8k]; halves are only taken at off 0 or 2.
  assign w_byte = word[{off, 3'b000} +: 8];
  assign w_half = word[{off[1], 4'b0000} +: 16];

  always_comb begin
    data  = '0;
    fault = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU: data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH: begin
        if (off[0]) fault = 1'b1;
        else        data  = {{(XLEN-16){w_half[15]}}, w_half};
      end
      F3_LHU: begin
        if (off[0]) fault = 1'b1;
        else        data  = {{(XLEN-16){1'b0}}, w_half};
      end
      F3_LW: begin
        if (off != 2'b00) fault = 1'b1;
        else              data  = word;
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register.
// Captures MEM-stage control/data every cycle, extracts the loaded value from
// the raw DMEM word (via load_ext) and presents registered results to the
// write-back mux and register file. One cycle latency, all outputs registered.
// Edge priority: reset (rst_n low, synchronous) > flush > stall > capture.
// Ports:
//   clk, rst_n            : clock (rising edge), synchronous active-low reset
//   stall / flush         : hold all outputs / insert a bubble
//   valid_i .. dmem_word_i: MEM-stage instruction fields and raw DMEM word
//   valid_o .. pc_o       : registered copies (rf_we_o is qualified)
//   dmem_rd_o             : extracted load data (0 unless a good DMEM load)
//   ld_fault_o            : misaligned/unsupported load now in WB
// Optional build macro MEM_WB_PERF_EN adds retired_cnt_o and stall_cnt_o.
module mem_wb_reg
  import wb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_i,
  input  logic [2:0]        wd_sel_i,
  input  logic              rf_we_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic [XLEN-1:0]   u_ext_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   dmem_word_i,
  output logic              valid_o,
  output logic [2:0]        wd_sel_o,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rd_o,
  output logic [XLEN-1:0]   alu_result_o,
  output logic [XLEN-1:0]   u_ext_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   dmem_rd_o,
  output logic              ld_fault_o
`ifdef MEM_WB_PERF_EN
  ,
  output logic [31:0]       retired_cnt_o,
  output logic [31:0]       stall_cnt_o
`endif
);

  logic [XLEN-1:0] w_ld_data;
  logic            w_ld_fault_raw;
  logic            w_is_load;
  logic            w_fault;
  logic [XLEN-1:0] w_dmem_rd;
  logic            w_rf_we;

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .funct3 (funct3_i),
    .off    (alu_result_i[1:0]),
    .word   (dmem_word_i),
    .data   (w_ld_data),
    .fault  (w_ld_fault_raw)
  );

  // Extraction results only matter for DMEM write-back; other selects never fault.
  assign w_is_load = (wd_sel_i == WD_SEL_DMEM);
  assign w_fault   = w_is_load & w_ld_fault_raw;
  assign w_dmem_rd = (w_is_load & ~w_ld_fault_raw) ? w_ld_data : '0;
  // x0 is hard-wired zero, so a write to it is dropped here rather than in the RF.
  assign w_rf_we   = valid_i & rf_we_i & (rd_i != '0) & ~w_fault;

  logic              r_valid;
  logic [2:0]        r_wd_sel;
  logic              r_rf_we;
  logic [REG_AW-1:0] r_rd;
  logic [XLEN-1:0]   r_alu_result;
  logic [XLEN-1:0]   r_u_ext;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_dmem_rd;
  logic              r_ld_fault;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_valid      <= 1'b0;
      r_wd_sel     <= 3'd0;
      r_rf_we      <= 1'b0;
      r_rd         <= '0;
      r_alu_result <= '0;
      r_u_ext      <= '0;
      r_pc         <= '0;
      r_dmem_rd    <= '0;
      r_ld_fault   <= 1'b0;
    end else if (!stall) begin
      r_valid      <= valid_i;
      r_wd_sel     <= wd_sel_i;
      r_rf_we      <= w_rf_we;
      r_rd         <= rd_i;
      r_alu_result <= alu_result_i;
      r_u_ext      <= u_ext_i;
      r_pc         <= pc_i;
      r_dmem_rd    <= w_dmem_rd;
      r_ld_fault   <= valid_i & w_fault;
    end
  end

  assign valid_o      = r_valid;
  assign wd_sel_o     = r_wd_sel;
  assign rf_we_o      = r_rf_we;
  assign rd_o         = r_rd;
  assign alu_result_o = r_alu_result;
  assign u_ext_o      = r_u_ext;
  assign pc_o         = r_pc;
  assign dmem_rd_o    = r_dmem_rd;
  assign ld_fault_o   = r_ld_fault;

`ifdef MEM_WB_PERF_EN
  logic [31:0] r_retired_cnt;
  logic [31:0] r_stall_cnt;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retired_cnt <= '0;
      r_stall_cnt   <= '0;
    end else begin
      if (!flush && !stall && valid_i) r_retired_cnt <= r_retired_cnt + 32'd1;
      if (stall && !flush)             r_stall_cnt   <= r_stall_cnt + 32'd1;
    end
  end

  assign retired_cnt_o = r_retired_cnt;
  assign stall_cnt_o   = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mem_wb_reg.sv
// Directed testbench for mem_wb_reg: reset, load extraction, load faults,
// x0 writes, stall/flush priority and (when built with MEM_WB_PERF_EN) counters.
module tb_mem_wb_reg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall;
  logic              flush;
  logic              valid_i;
  logic [2:0]        wd_sel_i;
  logic              rf_we_i;
  logic [REG_AW-1:0] rd_i;
  logic [2:0]        funct3_i;
  logic [XLEN-1:0]   alu_result_i;
  logic [XLEN-1:0]   u_ext_i;
  logic [XLEN-1:0]   pc_i;
  logic [XLEN-1:0]   dmem_word_i;
  logic              valid_o;
  logic [2:0]        wd_sel_o;
  logic              rf_we_o;
  logic [REG_AW-1:0] rd_o;
  logic [XLEN-1:0]   alu_result_o;
  logic [XLEN-1:0]   u_ext_o;
  logic [XLEN-1:0]   pc_o;
  logic [XLEN-1:0]   dmem_rd_o;
  logic              ld_fault_o;
`ifdef MEM_WB_PERF_EN
  logic [31:0]       retired_cnt_o;
  logic [31:0]       stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_reg #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .valid_i      (valid_i),
    .wd_sel_i     (wd_sel_i),
    .rf_we_i      (rf_we_i),
    .rd_i         (rd_i),
    .funct3_i     (funct3_i),
    .alu_result_i (alu_result_i),
    .u_ext_i      (u_ext_i),
    .pc_i         (pc_i),
    .dmem_word_i  (dmem_word_i),
    .valid_o      (valid_o),
    .wd_sel_o     (wd_sel_o),
    .rf_we_o      (rf_we_o),
    .rd_o         (rd_o),
    .alu_result_o (alu_result_o),
    .u_ext_o      (u_ext_o),
    .pc_o         (pc_o),
    .dmem_rd_o    (dmem_rd_o),
    .ld_fault_o   (ld_fault_o)
`ifdef MEM_WB_PERF_EN
    ,
    .retired_cnt_o(retired_cnt_o),
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] sel, input logic we,
                       input logic [4:0] rd, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc);
    valid_i      = v;
    wd_sel_i     = sel;
    rf_we_i      = we;
    rd_i         = rd;
    funct3_i     = f3;
    alu_result_i = alu;
    pc_i         = pc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 3'd2, 1'b1, 5'd9, 3'b000, 32'hDEAD_BEE1, 32'h0000_0040);
    u_ext_i = 32'h1234_5000; dmem_word_i = 32'h80FF_7F01;
    step();
    checks++;
    if ({valid_o, wd_sel_o, rf_we_o, rd_o, ld_fault_o} !== 11'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got valid=%b sel=%0d we=%b rd=%0d flt=%b, expected all 0",
               valid_o, wd_sel_o, rf_we_o, rd_o, ld_fault_o);
    end
    checks++;
    if ({alu_result_o, u_ext_o, pc_o, dmem_rd_o} !== 128'd0) begin
      errors++;
      $display("FAIL reset_data: got alu=%h uext=%h pc=%h dmem=%h, expected all 0",
               alu_result_o, u_ext_o, pc_o, dmem_rd_o);
    end
    $display("reset: outputs cleared check done");

    rst_n = 1'b1;
    drive(1'b1, 3'd1, 1'b1, 5'd5, 3'b000, 32'h0000_1234, 32'h0000_0044);
    step();
    checks++;
    if (wd_sel_o !== 3'd1 || rf_we_o !== 1'b1 || rd_o !== 5'd5 ||
        alu_result_o !== 32'h1234 || valid_o !== 1'b1 || dmem_rd_o !== 32'd0 ||
        u_ext_o !== 32'h1234_5000 || pc_o !== 32'h44) begin
      errors++;
      $display("FAIL alu_op: got sel=%0d we=%b rd=%0d alu=%h v=%b dmem=%h uext=%h pc=%h, expected 1 1 5 1234 1 0 12345000 44",
               wd_sel_o, rf_we_o, rd_o, alu_result_o, valid_o, dmem_rd_o, u_ext_o, pc_o);
    end
    $display("alu_op: sel=%0d rd=%0d alu=%h", wd_sel_o, rd_o, alu_result_o);
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b001};
    logic [1:0]  off [7] = '{2'd2,   2'd3,   2'd2,   2'd0,   2'd0,   2'd1,   2'd0};
    logic [31:0] exp [7] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
                             32'h80FF_7F01, 32'h0000_007F, 32'h0000_7F01};
    dmem_word_i = 32'h80FF_7F01;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 3'd2, 1'b1, 5'd7, f3[i], {30'h400, off[i]}, 32'h100 + 32'(i));
      step();
      checks++;
      if (dmem_rd_o !== exp[i] || ld_fault_o !== 1'b0 || rf_we_o !== 1'b1) begin
        errors++;
        $display("FAIL load_%0d: f3=%b off=%0d got data=%h flt=%b we=%b, expected data=%h flt=0 we=1",
                 i, f3[i], off[i], dmem_rd_o, ld_fault_o, rf_we_o, exp[i]);
      end
      $display("load f3=%b off=%0d data=%h", f3[i], off[i], dmem_rd_o);
    end
  endtask

  task automatic test_faults();
    logic [2:0] f3  [5] = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b101};
    logic [1:0] off [5] = '{2'd1,   2'd2,   2'd0,   2'd0,   2'd3};
    dmem_word_i = 32'h80FF_7F01;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'd2, 1'b1, 5'd8, f3[i], {30'h10, off[i]}, 32'h200);
      step();
      checks++;
      if (ld_fault_o !== 1'b1 || rf_we_o !== 1'b0 || dmem_rd_o !== 32'd0 || valid_o !== 1'b1) begin
        errors++;
        $display("FAIL fault_%0d: f3=%b off=%0d got flt=%b we=%b data=%h v=%b, expected 1 0 0 1",
                 i, f3[i], off[i], ld_fault_o, rf_we_o, dmem_rd_o, valid_o);
      end
      $display("fault f3=%b off=%0d flt=%b", f3[i], off[i], ld_fault_o);
    end
    // Bad funct3 on a non-load select must not fault.
    drive(1'b1, 3'd1, 1'b1, 5'd8, 3'b011, 32'h0000_0002, 32'h204);
    step();
    checks++;
    if (ld_fault_o !== 1'b0 || rf_we_o !== 1'b1 || dmem_rd_o !== 32'd0) begin
      errors++;
      $display("FAIL nonload_f3: got flt=%b we=%b data=%h, expected 0 1 0", ld_fault_o, rf_we_o, dmem_rd_o);
    end
    // Faulting load in a bubble: fault is masked by valid.
    drive(1'b0, 3'd2, 1'b1, 5'd8, 3'b010, 32'h0000_0002, 32'h208);
    step();
    checks++;
    if (ld_fault_o !== 1'b0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bubble_fault: got flt=%b v=%b, expected 0 0", ld_fault_o, valid_o);
    end
    $display("fault masking checks done");
  endtask

  task automatic test_x0();
    drive(1'b1, 3'd1, 1'b1, 5'd0, 3'b000, 32'h0000_0055, 32'h300);
    step();
    checks++;
    if (rf_we_o !== 1'b0 || valid_o !== 1'b1 || alu_result_o !== 32'h55) begin
      errors++;
      $display("FAIL x0_write: got we=%b v=%b alu=%h, expected 0 1 55", rf_we_o, valid_o, alu_result_o);
    end
    drive(1'b0, 3'd3, 1'b1, 5'd6, 3'b000, 32'h0000_0066, 32'h304);
    step();
    checks++;
    if (rf_we_o !== 1'b0 || valid_o !== 1'b0 || alu_result_o !== 32'h66 || pc_o !== 32'h304 || rd_o !== 5'd6) begin
      errors++;
      $display("FAIL bubble_capture: got we=%b v=%b alu=%h pc=%h rd=%0d, expected 0 0 66 304 6",
               rf_we_o, valid_o, alu_result_o, pc_o, rd_o);
    end
    $display("x0/bubble: we=%b v=%b", rf_we_o, valid_o);
  endtask

  task automatic test_stall_flush();
    // A: a faulting load, so stall must also hold ld_fault_o.
    dmem_word_i = 32'h80FF_7F01;
    drive(1'b1, 3'd2, 1'b1, 5'd3, 3'b010, 32'h0000_0A01, 32'h400);
    step();
    // B waits at the inputs while stalled.
    drive(1'b1, 3'd4, 1'b1, 5'd9, 3'b000, 32'h0000_0B00, 32'h500);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (rd_o !== 5'd3 || alu_result_o !== 32'hA01 || pc_o !== 32'h400 ||
          wd_sel_o !== 3'd2 || ld_fault_o !== 1'b1 || valid_o !== 1'b1 || rf_we_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_%0d: got rd=%0d alu=%h pc=%h sel=%0d flt=%b v=%b we=%b, expected 3 a01 400 2 1 1 0",
                 i, rd_o, alu_result_o, pc_o, wd_sel_o, ld_fault_o, valid_o, rf_we_o);
      end
      $display("stall cycle %0d: rd=%0d pc=%h", i, rd_o, pc_o);
    end
    flush = 1'b1;
    step();
    checks++;
    if (valid_o !== 1'b0 || rf_we_o !== 1'b0 || wd_sel_o !== 3'd0 || ld_fault_o !== 1'b0 ||
        alu_result_o !== 32'd0 || pc_o !== 32'd0 || dmem_rd_o !== 32'd0) begin
      errors++;
      $display("FAIL flush_over_stall: got v=%b we=%b sel=%0d flt=%b alu=%h pc=%h dmem=%h, expected all 0",
               valid_o, rf_we_o, wd_sel_o, ld_fault_o, alu_result_o, pc_o, dmem_rd_o);
    end
    stall = 1'b0; flush = 1'b0;
    step();
    checks++;
    if (valid_o !== 1'b1 || rd_o !== 5'd9 || pc_o !== 32'h500 || wd_sel_o !== 3'd4 ||
        rf_we_o !== 1'b1 || alu_result_o !== 32'hB00) begin
      errors++;
      $display("FAIL capture_b: got v=%b rd=%0d pc=%h sel=%0d we=%b alu=%h, expected 1 9 500 4 1 b00",
               valid_o, rd_o, pc_o, wd_sel_o, rf_we_o, alu_result_o);
    end
    $display("after flush: captured rd=%0d pc=%h", rd_o, pc_o);
    // Reset wins over stall and flush.
    stall = 1'b1; flush = 1'b1; rst_n = 1'b0;
    step();
    checks++;
    if (valid_o !== 1'b0 || rd_o !== 5'd0 || pc_o !== 32'd0 || wd_sel_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_stall: got v=%b rd=%0d pc=%h sel=%0d, expected all 0", valid_o, rd_o, pc_o, wd_sel_o);
    end
    stall = 1'b0; flush = 1'b0; rst_n = 1'b1;
    $display("reset during stall/flush check done");
  endtask

`ifdef MEM_WB_PERF_EN
  task automatic test_perf();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd1, 1'b1, 5'd1, 3'b000, 32'(i), 32'(i * 4));
      step();
    end
    drive(1'b0, 3'd1, 1'b0, 5'd1, 3'b000, 32'd0, 32'd0);
    step();
    drive(1'b1, 3'd1, 1'b1, 5'd1, 3'b000, 32'd9, 32'd0);
    stall = 1'b1;
    step();
    step();
    flush = 1'b1;
    step();
    stall = 1'b0; flush = 1'b0;
    valid_i = 1'b0;
    checks++;
    if (retired_cnt_o !== 32'd4 || stall_cnt_o !== 32'd2) begin
      errors++;
      $display("FAIL perf_counts: got retired=%0d stalls=%0d, expected 4 2", retired_cnt_o, stall_cnt_o);
    end
    $display("perf: retired=%0d stalls=%0d", retired_cnt_o, stall_cnt_o);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (retired_cnt_o !== 32'd0 || stall_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset: got retired=%0d stalls=%0d, expected 0 0", retired_cnt_o, stall_cnt_o);
    end
    $display("perf after reset: retired=%0d stalls=%0d", retired_cnt_o, stall_cnt_o);
  endtask
`endif

  initial begin
    test_reset();
    test_loads();
    test_faults();
    test_x0();
    test_stall_flush();
`ifdef MEM_WB_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
